// File: rtl/sgm_pkg.sv
// Shared definitions for the sum/mean datapath: width derivations used by both
// the adder tree and the divider, plus the divider FSM state encoding.
package sgm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the adder-tree sum of arr_l elements, each data_depth bits wide.
    function automatic int sum_depth(input int data_depth, input int arr_l);
        return $clog2(arr_l) + data_depth;
    endfunction

    // Width that can hold any element count from 0 to arr_l.
    function automatic int cnt_depth(input int arr_l);
        return $clog2(arr_l + 1);
    endfunction

endpackage

// File: rtl/sum_divider.sv
// Sequential restoring divider: divides an adder-tree sum by its element count,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module sum_divider
    import sgm_pkg::*;
#(
    parameter  int data_depth = 8,
    parameter  int ArrL       = 4,
    localparam int sumDepth   = sum_depth(data_depth, ArrL),
    localparam int cntDepth   = cnt_depth(ArrL)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [sumDepth-1:0] SumIn,
    input  logic [cntDepth-1:0] Divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [sumDepth-1:0] Quot,
    output logic [cntDepth-1:0] Rem,
    output logic                DivZero
);

    localparam int IterW = $clog2(sumDepth + 1);

    state_e              state_q;
    logic [IterW-1:0]    iter_q;
    logic [sumDepth-1:0] dvd_q;      // dividend shifts out MSB first, quotient bits shift in
    logic [cntDepth-1:0] dsr_q;
    logic [cntDepth:0]   rem_q;
    logic [sumDepth-1:0] quot_q;
    logic [cntDepth-1:0] rem_out_q;
    logic                div_zero_q;

    logic [cntDepth:0]   rem_shift;
    logic                q_bit;
    logic [cntDepth:0]   rem_d;
    logic [sumDepth-1:0] dvd_d;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        rem_shift = (rem_q << 1) | {{cntDepth{1'b0}}, dvd_q[sumDepth-1]};
        q_bit     = rem_shift >= {1'b0, dsr_q};
        rem_d     = q_bit ? (rem_shift - {1'b0, dsr_q}) : rem_shift;
        dvd_d     = {dvd_q[sumDepth-2:0], q_bit};
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            rem_out_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q <= SumIn;
                        dsr_q <= Divisor;
                        rem_q <= '0;
                        if (Divisor == '0) begin
                            quot_q     <= '1;
                            rem_out_q  <= '0;
                            div_zero_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            iter_q  <= IterW'(sumDepth);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_q  <= dvd_d;
                    rem_q  <= rem_d;
                    iter_q <= iter_q - IterW'(1);
                    if (iter_q == IterW'(1)) begin
                        quot_q     <= dvd_d;
                        rem_out_q  <= rem_d[cntDepth-1:0];
                        div_zero_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Quot      = quot_q;
    assign Rem       = rem_out_q;
    assign DivZero   = div_zero_q;

endmodule

// File: tb/tb_sum_divider.sv
// Directed bench for sum_divider at data_depth=8, ArrL=4 (10-bit sum, 3-bit count).
module tb_sum_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] SumIn = '0;
    logic [2:0] Divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] Quot;
    logic [2:0] Rem;
    logic       DivZero;

    int asserts  = 0;
    int failures = 0;

    sum_divider #(.data_depth(8), .ArrL(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .SumIn(SumIn), .Divisor(Divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .Quot(Quot), .Rem(Rem), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    // Present an operand pair and return #1 after the accepting edge.
    task automatic start_op(input logic [9:0] s, input logic [2:0] d);
        @(negedge clk);
        SumIn = s; Divisor = d; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid (-1 on timeout);
    // ready_leak flags in_ready seen high while a result was pending.
    task automatic wait_result(output int edges, output bit ready_leak);
        edges = 0;
        ready_leak = 1'b0;
        while (!out_valid && edges < 50) begin
            if (in_ready) ready_leak = 1'b1;
            @(posedge clk);
            #1 edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        asserts++; if (Quot !== 10'd0 || Rem !== 3'd0 || DivZero !== 1'b0) begin
            failures++; $display("FAIL reset_outputs: got Quot=%0d Rem=%0d DivZero=%b want 0/0/0", Quot, Rem, DivZero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_exact();
        int e; bit leak;
        start_op(10'd1020, 3'd4);
        wait_result(e, leak);
        asserts++; if (e != 10) begin failures++; $display("FAIL exact_latency: got %0d edges want 10", e); end
        asserts++; if (leak) begin failures++; $display("FAIL exact_in_ready_busy: got in_ready=1 while busy want 0"); end
        asserts++; if (Quot !== 10'd255 || Rem !== 3'd0 || DivZero !== 1'b0) begin
            failures++; $display("FAIL exact_result: got Quot=%0d Rem=%0d DivZero=%b want 255/0/0", Quot, Rem, DivZero);
        end
        consume();
        asserts++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL exact_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_small();
        int e; bit leak;
        start_op(10'd7, 3'd3);
        wait_result(e, leak);
        asserts++; if (e != 10 || Quot !== 10'd2 || Rem !== 3'd1 || DivZero !== 1'b0) begin
            failures++; $display("FAIL small_7_3: got edges=%0d Quot=%0d Rem=%0d DZ=%b want 10/2/1/0", e, Quot, Rem, DivZero);
        end
        consume();
        start_op(10'd0, 3'd1);
        wait_result(e, leak);
        asserts++; if (e != 10 || Quot !== 10'd0 || Rem !== 3'd0 || DivZero !== 1'b0) begin
            failures++; $display("FAIL small_0_1: got edges=%0d Quot=%0d Rem=%0d DZ=%b want 10/0/0/0", e, Quot, Rem, DivZero);
        end
        consume();
        start_op(10'd1023, 3'd7);
        wait_result(e, leak);
        asserts++; if (Quot !== 10'd146 || Rem !== 3'd1) begin
            failures++; $display("FAIL max_by_7: got Quot=%0d Rem=%0d want 146/1", Quot, Rem);
        end
        consume();
    endtask

    task automatic test_div_zero();
        int e; bit leak;
        start_op(10'd5, 3'd0);
        wait_result(e, leak);
        asserts++; if (e != 0) begin failures++; $display("FAIL div0_latency: got %0d extra edges want 0", e); end
        asserts++; if (Quot !== 10'd1023 || Rem !== 3'd0 || DivZero !== 1'b1) begin
            failures++; $display("FAIL div0_result: got Quot=%0d Rem=%0d DivZero=%b want 1023/0/1", Quot, Rem, DivZero);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int e; bit leak;
        int bad = 0;
        start_op(10'd1023, 3'd4);
        wait_result(e, leak);
        asserts++; if (Quot !== 10'd255 || Rem !== 3'd3 || DivZero !== 1'b0) begin
            failures++; $display("FAIL hold_initial: got Quot=%0d Rem=%0d DivZero=%b want 255/3/0", Quot, Rem, DivZero);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            SumIn    = 10'd17;
            Divisor  = 3'd2;
            @(posedge clk);
            #1;
            if (Quot !== 10'd255 || Rem !== 3'd3 || DivZero !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        asserts++; if (bad != 0) begin failures++; $display("FAIL hold_stable: got %0d disturbed cycles want 0", bad); end
        consume();
        asserts++; if (Quot !== 10'd255 || Rem !== 3'd3 || in_ready !== 1'b1) begin
            failures++; $display("FAIL hold_idle_keep: got Quot=%0d Rem=%0d in_ready=%b want 255/3/1", Quot, Rem, in_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        int e; bit leak;
        start_op(10'd100, 3'd3);
        repeat (4) @(posedge clk);
        #2;
        asserts++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL midreset_busy: got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        asserts++; if (Quot !== 10'd0 || Rem !== 3'd0 || DivZero !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_outputs: got Quot=%0d Rem=%0d DZ=%b ov=%b ir=%b want 0/0/0/0/1",
                                 Quot, Rem, DivZero, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(10'd9, 3'd2);
        wait_result(e, leak);
        asserts++; if (e != 10 || Quot !== 10'd4 || Rem !== 3'd1 || DivZero !== 1'b0) begin
            failures++; $display("FAIL after_reset_9_2: got edges=%0d Quot=%0d Rem=%0d DZ=%b want 10/4/1/0", e, Quot, Rem, DivZero);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_exact();
        test_small();
        test_div_zero();
        test_backpressure();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
